// File: rtl/flash_hex_formatter_if.sv
`default_nettype none
// ============================================================================
// Module      : flash_hex_formatter_if
// Description : Read-result input, status and character read port bundle
//               for the flash hex line formatter.
// Revision    : 1.0 - initial release
// ============================================================================
interface flash_hex_formatter_if #(
    parameter int MEMORY_LENGTH = 4,
    parameter int ADDR_WIDTH    = 24,
    parameter int INDEX_WIDTH   = 5
);
    logic [MEMORY_LENGTH*8-1:0] data_in;
    logic [ADDR_WIDTH-1:0]      addr_in;
    logic                       data_valid;
    logic                       busy;
    logic                       frame_done;
    logic [INDEX_WIDTH-1:0]     char_index;
    logic [7:0]                 char_out;

    modport master (
        output data_in,
        output addr_in,
        output data_valid,
        output char_index,
        input  busy,
        input  frame_done,
        input  char_out
    );

    modport slave (
        input  data_in,
        input  addr_in,
        input  data_valid,
        input  char_index,
        output busy,
        output frame_done,
        output char_out
    );
endinterface
`default_nettype wire

// File: rtl/flash_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module      : flash_hex_formatter
// Description : Converts a flash read result into an "AAAAAA: DDDDDDDD" ASCII
//               line buffer, one character per clock, with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_hex_formatter #(
    parameter int MEMORY_LENGTH = 4,
    parameter int ADDR_WIDTH    = 24,
    parameter int BUF_CHARS     = 16,
    parameter int INDEX_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    flash_hex_formatter_if.slave bus
);

    localparam int c_ADDR_NIBS  = ADDR_WIDTH / 4;
    localparam int c_DATA_START = c_ADDR_NIBS + 2;
    localparam int c_DATA_NIBS  = 2 * MEMORY_LENGTH;
    localparam logic [INDEX_WIDTH-1:0] c_LAST_POS  = INDEX_WIDTH'(BUF_CHARS - 1);
    localparam logic [INDEX_WIDTH-1:0] c_COLON_POS = INDEX_WIDTH'(c_ADDR_NIBS);
    localparam logic [7:0] c_SPACE = 8'h20;
    localparam logic [7:0] c_COLON = 8'h3A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_validQ;
    logic [MEMORY_LENGTH*8-1:0] r_dataShadow;
    logic [ADDR_WIDTH-1:0]      r_addrShadow;
    logic [INDEX_WIDTH-1:0]     r_pos;
    logic                       r_busy;
    logic                       r_frameDone;
    logic [7:0]                 r_buf [BUF_CHARS];
    logic [7:0]                 r_charOut;

    logic                       w_start;
    logic [3:0]                 w_nibble;
    logic                       w_isHex;
    logic [7:0]                 w_char;
    logic [7:0]                 w_readChar;

    function automatic logic [7:0] toAscii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign w_start        = bus.data_valid && !r_validQ;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frameDone;
    assign bus.char_out   = r_charOut;

    // Character for the current write position, taken from the shadow copies only.
    always_comb begin
        w_nibble = 4'h0;
        w_isHex  = 1'b0;
        w_char   = c_SPACE;
        for (int i = 0; i < c_ADDR_NIBS; i++) begin
            if (r_pos == INDEX_WIDTH'(i)) begin
                w_nibble = r_addrShadow[ADDR_WIDTH-1-4*i -: 4];
                w_isHex  = 1'b1;
            end
        end
        for (int j = 0; j < c_DATA_NIBS; j++) begin
            if (r_pos == INDEX_WIDTH'(c_DATA_START + j)) begin
                // Byte 0 first; within a byte the high nibble comes first.
                w_nibble = r_dataShadow[8*(j/2) + ((j % 2 == 0) ? 7 : 3) -: 4];
                w_isHex  = 1'b1;
            end
        end
        if (r_pos == c_COLON_POS) begin
            w_char = c_COLON;
        end
        if (w_isHex) begin
            w_char = toAscii(w_nibble);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_validQ     <= 1'b0;
            r_dataShadow <= '0;
            r_addrShadow <= '0;
            r_pos        <= '0;
            r_busy       <= 1'b0;
            r_frameDone  <= 1'b0;
            for (int i = 0; i < BUF_CHARS; i++) begin
                r_buf[i] <= c_SPACE;
            end
        end else begin
            r_validQ <= bus.data_valid;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dataShadow <= bus.data_in;
                        r_addrShadow <= bus.addr_in;
                        r_pos        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    for (int i = 0; i < BUF_CHARS; i++) begin
                        if (r_pos == INDEX_WIDTH'(i)) begin
                            r_buf[i] <= w_char;
                        end
                    end
                    if (r_pos == c_LAST_POS) begin
                        r_busy      <= 1'b0;
                        r_frameDone <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_pos <= r_pos + INDEX_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    r_frameDone <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Indices past the end of the line read back as spaces.
    always_comb begin
        w_readChar = c_SPACE;
        for (int i = 0; i < BUF_CHARS; i++) begin
            if (bus.char_index == INDEX_WIDTH'(i)) begin
                w_readChar = r_buf[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_charOut <= c_SPACE;
        end else begin
            r_charOut <= w_readChar;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_hex_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_hex_formatter
// Description : Self-checking bench for flash_hex_formatter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_hex_formatter;
    localparam int c_ML = 4;
    localparam int c_AW = 24;
    localparam int c_BC = 16;
    localparam int c_IW = 5;
    localparam int c_NVEC = 5;

    typedef struct packed {
        logic [23:0]    addr;
        logic [31:0]    data;
        logic [127:0]   line;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   nTests = 0;
    int   nFail = 0;
    int   doneCount = 0;
    logic [7:0] expQ [$];
    vec_t vecs [c_NVEC];

    always #5 clk = ~clk;

    flash_hex_formatter_if #(.MEMORY_LENGTH(c_ML), .ADDR_WIDTH(c_AW), .INDEX_WIDTH(c_IW)) bus ();

    flash_hex_formatter #(
        .MEMORY_LENGTH(c_ML),
        .ADDR_WIDTH   (c_AW),
        .BUF_CHARS    (c_BC),
        .INDEX_WIDTH  (c_IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) doneCount++;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nTests++;
        if (act !== want) begin
            nFail++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    function automatic logic [127:0] expLine(input logic [23:0] a, input logic [31:0] d);
        string      hex = "0123456789ABCDEF";
        logic [7:0] c [16];
        logic [127:0] l;
        for (int i = 0; i < 6; i++) c[i] = hex[int'(a[23-4*i -: 4])];
        c[6] = 8'h3A;
        c[7] = 8'h20;
        for (int b = 0; b < 4; b++) begin
            c[8+2*b] = hex[int'(d[8*b+7 -: 4])];
            c[9+2*b] = hex[int'(d[8*b+3 -: 4])];
        end
        for (int i = 0; i < 16; i++) l[8*(15-i) +: 8] = c[i];
        return l;
    endfunction

    task automatic pushLine(input logic [127:0] l);
        for (int i = 0; i < 16; i++) expQ.push_back(l[8*(15-i) +: 8]);
        for (int i = 16; i < 32; i++) expQ.push_back(8'h20);
    endtask

    task automatic pushBlank();
        for (int i = 0; i < 32; i++) expQ.push_back(8'h20);
    endtask

    task automatic startFrame(input logic [23:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr_in    = a;
        bus.data_in    = d;
        bus.data_valid = 1'b1;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (bus.frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " frame_done"}, 32'(bus.frame_done === 1'b1), 32'd1);
    endtask

    task automatic readBuffer(input string name);
        logic [7:0] want;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.char_index = c_IW'(i);
            @(negedge clk);
            want = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
            check($sformatf("%s char[%0d]", name, i), 32'(bus.char_out), 32'(want));
        end
    endtask

    initial begin
        int d0;
        vecs[0] = '{addr: 24'h000000, data: 32'h44332211, line: "000000: 11223344"};
        vecs[1] = '{addr: 24'hABCDEF, data: 32'hEFBEADDE, line: "ABCDEF: DEADBEEF"};
        vecs[2] = '{addr: 24'h123456, data: 32'h78563412, line: "123456: 12345678"};
        vecs[3] = '{addr: 24'hFFFFFF, data: 32'h00FF00A5, line: "FFFFFF: A500FF00"};
        vecs[4] = '{addr: 24'h09AF10, data: 32'hC0B0A090, line: "09AF10: 90A0B0C0"};

        rst = 1'b1;
        bus.data_in = '0;
        bus.addr_in = '0;
        bus.data_valid = 1'b0;
        bus.char_index = '0;
        repeat (3) @(negedge clk);
        check("reset char_out", 32'(bus.char_out), 32'h20);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        pushBlank();
        readBuffer("reset");

        // Timing of busy / frame_done around a single frame.
        startFrame(24'hABCDEF, 32'hEFBEADDE);
        pushLine(expLine(24'hABCDEF, 32'hEFBEADDE));
        @(negedge clk);
        check("timing busy after start", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("timing busy/fd N+%0d", i), {30'd0, bus.busy, bus.frame_done}, 32'b10);
        end
        @(negedge clk);
        check("timing N+16 busy/fd", {30'd0, bus.busy, bus.frame_done}, 32'b01);
        @(negedge clk);
        check("timing N+17 frame_done", 32'(bus.frame_done), 32'd0);
        bus.data_valid = 1'b0;
        readBuffer("timing");

        for (int v = 0; v < c_NVEC; v++) begin
            startFrame(vecs[v].addr, vecs[v].data);
            pushLine(vecs[v].line);
            waitDone($sformatf("vec%0d", v));
            @(negedge clk);
            bus.data_valid = 1'b0;
            readBuffer($sformatf("vec%0d", v));
        end

        // Held valid gives one frame; a retrigger mid-frame is ignored.
        d0 = doneCount;
        startFrame(24'h111111, 32'h22222222);
        pushLine(expLine(24'h111111, 32'h22222222));
        repeat (100) @(negedge clk);
        check("held valid frame count", 32'(doneCount - d0), 32'd1);
        bus.data_valid = 1'b0;
        readBuffer("held");
        d0 = doneCount;
        startFrame(24'h3C3C3C, 32'h0BADF00D);
        pushLine(expLine(24'h3C3C3C, 32'h0BADF00D));
        repeat (5) @(negedge clk);
        bus.data_valid = 1'b0;
        @(negedge clk);
        bus.addr_in = 24'h999999;
        bus.data_in = 32'h77777777;
        bus.data_valid = 1'b1;
        repeat (40) @(negedge clk);
        check("retrigger frame count", 32'(doneCount - d0), 32'd1);
        bus.data_valid = 1'b0;
        readBuffer("retrigger");

        // Inputs change right after the start event.
        startFrame(24'h5A5A5A, 32'hCAFEBABE);
        pushLine(expLine(24'h5A5A5A, 32'hCAFEBABE));
        @(negedge clk);
        bus.data_in = '0;
        bus.addr_in = '0;
        waitDone("isolation");
        @(negedge clk);
        bus.data_valid = 1'b0;
        readBuffer("isolation");

        // Reset in the middle of a write.
        d0 = doneCount;
        startFrame(24'h0F0F0F, 32'h87654321);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        bus.data_valid = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset char_out", 32'(bus.char_out), 32'h20);
        @(negedge clk);
        rst = 1'b0;
        pushBlank();
        readBuffer("midreset");
        check("midreset no frame_done", 32'(doneCount - d0), 32'd0);
        startFrame(24'hFEDCBA, 32'h98765432);
        pushLine(expLine(24'hFEDCBA, 32'h98765432));
        waitDone("after reset");
        @(negedge clk);
        bus.data_valid = 1'b0;
        readBuffer("after reset");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/flash_hex_formatter.md
Name: flash_hex_formatter

Overview:
- Downstream consumer of the SPI flash reader's output word.
- On each new read result, it converts the flash address and the MEMORY_LENGTH data bytes into an ASCII hex text line. The line is held in a character buffer.
- The screen/console text renderer reads the buffer by index with 1-cycle latency.
- The format engine writes one character per clock, so a full line takes BUF_CHARS clocks.

Parameters:
- MEMORY_LENGTH, 4, number of data bytes in data_in. Must match the flash reader.
- ADDR_WIDTH, 24, width of addr_in. Must be a multiple of 4.
- BUF_CHARS, 16, number of characters in the line buffer. Must be >= ADDR_WIDTH/4 + 2 + 2*MEMORY_LENGTH.
- INDEX_WIDTH, 5, width of char_index. Must satisfy 2**INDEX_WIDTH >= BUF_CHARS.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  MEMORY_LENGTH*8  read data word; byte k = data_in[8k+7:8k].
- addr_in  in  ADDR_WIDTH  flash address the word was read from.
- data_valid  in  1  level from the flash reader; high while the result is stable.
- busy  out  1  high while the line is being written.
- frame_done  out  1  one-clock pulse when a complete line has been written.
- char_index  in  INDEX_WIDTH  character position requested by the renderer.
- char_out  out  8  ASCII code at char_index, registered.

Behaviour:
- Reset (async assert, sync release): all outputs and state are forced at once.
  - state=IDLE, busy=0, frame_done=0, char_out=0x20.
  - Every buffer entry = 0x20 (space); data_valid edge detector history = 0.
- Edge detect: valid_q <= data_valid every clock. A start event is data_valid=1 && valid_q=0, sampled in IDLE only.
- IDLE: on a start event:
  - Latch data_in and addr_in into shadow registers.
  - pos <= 0, busy <= 1, go to WRITE.
  - Otherwise hold.
- WRITE: each clock, buf[pos] <= char(pos), pos <= pos+1.
  - After writing pos = BUF_CHARS-1: busy <= 0, frame_done <= 1, go to DONE.
- DONE: frame_done <= 0, go to IDLE. frame_done is therefore high for exactly 1 clock.
- Latency: for a start event sampled at edge N, chars are written at edges N+1..N+BUF_CHARS. frame_done is high in the cycle after edge N+BUF_CHARS.
- Line layout (A = ADDR_WIDTH/4):
  - Positions 0..A-1: address nibbles, MSB nibble first.
  - Position A: ':' (0x3A).
  - Position A+1: ' ' (0x20).
  - Next 2*MEMORY_LENGTH positions: data bytes, byte 0 first, high nibble before low nibble within each byte.
  - Remaining positions up to BUF_CHARS-1: 0x20.
- Nibble to ASCII: 0..9 -> 0x30..0x39; 10..15 -> 0x41..0x46 (uppercase).
- Read port: char_out <= buf[char_index] each clock, giving 1-cycle latency.
  - char_index >= BUF_CHARS returns 0x20.
  - A read and write to the same index in the same cycle returns the old value.
  - Reads during WRITE may return a mix of old and new line; no tear protection.
- Start events while busy or in DONE are ignored and lost. valid_q keeps tracking, so data_valid held high never retriggers. A new frame needs data_valid to fall and rise again.
- Shadow registers isolate conversion from data_in/addr_in changes during WRITE.
- rst mid-WRITE: buffer returns to all spaces, busy=0, no frame_done is produced. A start event needs data_valid low then high after reset release.

Test Plan:
1. Reset check: assert rst, release, sweep char_index 0..31 -> char_out=0x20 at every index one clock later; busy=0; frame_done=0.
2. Basic format: addr_in=0x000000, data_in=32'h44332211, raise data_valid -> after frame_done, indices 0..15 read "000000: 11223344". This is 0x30 x6, 0x3A, 0x20, 0x31,0x31,0x32,0x32,0x33,0x33,0x34,0x34.
3. Hex letters and timing: addr_in=0xABCDEF, data_in=32'hEFBEADDE, data_valid rises, sampled at edge N.
   - busy is high from N+1 through N+16; frame_done is high only in the cycle after edge N+16.
   - The line reads "ABCDEF: DEADBEEF".
4. Held and retriggered valid: hold data_valid high for 100 clocks -> exactly one frame_done. Then pulse data_valid low→high at clock 5 of a new frame -> no second frame_done, buffer holds the first frame's content.
5. Input isolation: change data_in to 32'h0 on the clock after the start event -> the buffer still holds the originally latched value.
6. Reset mid-operation: assert rst at clock 7 of WRITE -> busy=0 immediately, all indices read 0x20, no frame_done. A subsequent valid edge produces a correct full line.
